// File: rtl/branch_target_table.sv
// Multi-bank, runtime-loadable branch-target table: combinational read port plus
// a serial loader FSM that fills one bank entry by entry.
module branch_target_table #(
  parameter int ADDR_W    = 5,
  parameter int TARGET_W  = 10,
  parameter int NUM_BANKS = 3,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [BANK_W-1:0]   BankSel,
  input  logic [ADDR_W-1:0]   Addr,
  output logic [TARGET_W-1:0] Target,
  output logic                Hit,
  input  logic                LoadStart,
  input  logic [BANK_W-1:0]   LoadBank,
  input  logic [ADDR_W-1:0]   LoadLen,
  input  logic [TARGET_W-1:0] LoadData,
  input  logic                LoadValid,
  output logic                LoadReady,
  input  logic                LoadAbort,
  output logic                LoadDone,
  output logic                LoadErr,
  output logic                Busy,
  output logic [1:0]          DbgState
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [BANK_W:0] NB     = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W + 1)'(1);

  // Load handshake: a data beat transfers on a cycle where LoadValid and
  // LoadReady are both high and LoadAbort is low; LoadReady is high only in LOAD.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [BANK_W-1:0]   cur_bank;
  logic [ADDR_W:0]     len;
  logic [ADDR_W-1:0]   ptr;
  logic                load_err_q;
  logic [DEPTH-1:0]    valid [NUM_BANKS];
  logic [TARGET_W-1:0] mem   [NUM_BANKS][DEPTH];

  logic                bank_ok;
  logic                start_ok;
  logic                start_bad;
  logic                wr_en;
  logic                last;
  logic                rd_ok;
  logic [BANK_W-1:0]   rd_bank;

  assign bank_ok   = ({1'b0, LoadBank} < NB);
  assign start_ok  = (state == IDLE) && LoadStart && bank_ok;
  assign start_bad = (state == IDLE) && LoadStart && !bank_ok;
  assign wr_en     = (state == LOAD) && LoadValid && !LoadAbort;
  assign last      = ({1'b0, ptr} == (len - ONE));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: begin
        if (LoadAbort) begin
          state_next = IDLE;
        end else if (wr_en && last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_bank   <= '0;
      len        <= '0;
      ptr        <= '0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= start_bad;
      if (start_ok) begin
        cur_bank <= LoadBank;
        len      <= (LoadLen == '0) ? FULL : {1'b0, LoadLen};
        ptr      <= '0;
      end else if (wr_en) begin
        // A full-depth load wraps ptr to 0 on its last write; DONE follows, so it is never reused.
        ptr <= ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) valid[b] <= '0;
    end else if (start_ok) begin
      valid[LoadBank] <= '0;
    end else if (wr_en) begin
      valid[cur_bank][ptr] <= 1'b1;
    end
  end

  // Table contents are deliberately left unreset; the valid bits gate every read.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[cur_bank][ptr] <= LoadData;
  end

  // The bank under load is locked only while entries are still arriving;
  // it becomes readable in the DONE cycle.
  assign rd_ok   = ({1'b0, BankSel} < NB);
  assign rd_bank = rd_ok ? BankSel : '0;
  assign Hit     = rd_ok && valid[rd_bank][Addr] && !((state == LOAD) && (BankSel == cur_bank));
  assign Target  = Hit ? mem[rd_bank][Addr] : '0;

  assign LoadReady = (state == LOAD);
  assign LoadDone  = (state == DONE);
  assign LoadErr   = load_err_q;
  assign Busy      = (state != IDLE);
  assign DbgState  = state;

endmodule

// File: tb/tb_branch_target_table.sv
// Randomized bench for branch_target_table: per-cycle compare against a
// table-level model plus directed literal checks of the load scenarios.
module tb_branch_target_table;

  localparam int ADDR_W    = 5;
  localparam int TARGET_W  = 10;
  localparam int NUM_BANKS = 3;
  localparam int BANK_W    = 2;
  localparam int DEPTH     = 32;

  logic                Clk;
  logic                Reset_n;
  logic [BANK_W-1:0]   BankSel;
  logic [ADDR_W-1:0]   Addr;
  logic [TARGET_W-1:0] Target;
  logic                Hit;
  logic                LoadStart;
  logic [BANK_W-1:0]   LoadBank;
  logic [ADDR_W-1:0]   LoadLen;
  logic [TARGET_W-1:0] LoadData;
  logic                LoadValid;
  logic                LoadReady;
  logic                LoadAbort;
  logic                LoadDone;
  logic                LoadErr;
  logic                Busy;
  logic [1:0]          DbgState;

  branch_target_table #(
    .ADDR_W(ADDR_W), .TARGET_W(TARGET_W), .NUM_BANKS(NUM_BANKS)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .BankSel(BankSel), .Addr(Addr),
    .Target(Target), .Hit(Hit), .LoadStart(LoadStart), .LoadBank(LoadBank),
    .LoadLen(LoadLen), .LoadData(LoadData), .LoadValid(LoadValid),
    .LoadReady(LoadReady), .LoadAbort(LoadAbort), .LoadDone(LoadDone),
    .LoadErr(LoadErr), .Busy(Busy), .DbgState(DbgState)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int passes = 0;
  int ready_cnt = 0;
  int done_cnt  = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Table contents as the loader should have left them, plus the progress of
  // the current load expressed as "entries still to come".
  logic [TARGET_W-1:0] m_mem   [NUM_BANKS][DEPTH];
  bit                  m_valid [NUM_BANKS][DEPTH];
  int m_bank = 0;
  int m_remaining = 0;
  int m_idx = 0;
  bit m_done = 0;
  bit m_err = 0;
  bit m_was_done;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int a = 0; a < DEPTH; a++) m_valid[b][a] = 0;
      m_remaining = 0;
      m_done = 0;
      m_err = 0;
    end else begin
      m_was_done = m_done;
      m_done = 0;
      m_err = 0;
      if (m_remaining > 0) begin
        if (LoadAbort) begin
          m_remaining = 0;
        end else if (LoadValid) begin
          m_mem[m_bank][m_idx]   = LoadData;
          m_valid[m_bank][m_idx] = 1;
          m_idx++;
          m_remaining--;
          if (m_remaining == 0) m_done = 1;
        end
      end else if (!m_was_done && LoadStart) begin
        if (int'(LoadBank) >= NUM_BANKS) begin
          m_err = 1;
        end else begin
          m_bank = int'(LoadBank);
          m_remaining = (LoadLen == 0) ? DEPTH : int'(LoadLen);
          m_idx = 0;
          for (int a = 0; a < DEPTH; a++) m_valid[m_bank][a] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic                exp_hit;
  logic [TARGET_W-1:0] exp_tgt;

  always @(negedge Clk) begin
    if (Reset_n && cmp_en) begin
      exp_hit = 1'b0;
      exp_tgt = '0;
      if (int'(BankSel) < NUM_BANKS) begin
        exp_hit = m_valid[BankSel][Addr] && !(m_remaining > 0 && int'(BankSel) == m_bank);
        if (exp_hit) exp_tgt = m_mem[BankSel][Addr];
      end
      check("hit",        32'(Hit),       32'(exp_hit));
      check("target",     32'(Target),    32'(exp_tgt));
      check("load_ready", 32'(LoadReady), 32'(m_remaining > 0));
      check("load_done",  32'(LoadDone),  32'(m_done));
      check("load_err",   32'(LoadErr),   32'(m_err));
      check("busy",       32'(Busy),      32'(m_remaining > 0 || m_done));
      if (LoadReady) ready_cnt++;
      if (LoadDone)  done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
    BankSel = BANK_W'($urandom_range(0, 3));
    Addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic start_load(input int bank, input int len);
    LoadStart = 1'b1;
    LoadBank  = BANK_W'(bank);
    LoadLen   = ADDR_W'(len);
    tick();
    LoadStart = 1'b0;
  endtask

  task automatic feed(input logic [TARGET_W-1:0] d, input int stalls);
    repeat (stalls) begin
      LoadValid = 1'b0;
      LoadData  = TARGET_W'($urandom);
      LoadStart = ($urandom_range(0, 3) == 0);
      LoadBank  = BANK_W'($urandom_range(0, 3));
      tick();
    end
    LoadStart = 1'b0;
    LoadValid = 1'b1;
    LoadData  = d;
    tick();
    LoadValid = 1'b0;
  endtask

  task automatic finish_load();
    LoadValid = 1'b0;
    LoadAbort = 1'(($urandom_range(0, 1)));
    tick();
    LoadAbort = 1'b0;
    tick();
  endtask

  task automatic abort_now();
    LoadValid = 1'b1;
    LoadData  = 10'h3ff;
    LoadAbort = 1'b1;
    tick();
    LoadAbort = 1'b0;
    LoadValid = 1'b0;
  endtask

  logic [TARGET_W-1:0] t1_data [10] = '{10'h013, 10'h026, 10'h019, 10'h0a5, 10'h1c3,
                                        10'h2f0, 10'h077, 10'h301, 10'h15e, 10'h0c9};

  // ---------------- stimulus ----------------
  initial begin
    int n, abort_at, bank, len, done_before;
    Reset_n = 1'b0; BankSel = '0; Addr = '0; LoadStart = 1'b0; LoadBank = '0;
    LoadLen = '0; LoadData = '0; LoadValid = 1'b0; LoadAbort = 1'b0;

    #1;
    check("rst_busy",  32'(Busy),      32'd0);
    check("rst_ready", 32'(LoadReady), 32'd0);
    check("rst_done",  32'(LoadDone),  32'd0);
    check("rst_err",   32'(LoadErr),   32'd0);
    check("rst_hit",   32'(Hit),       32'd0);
    check("rst_tgt",   32'(Target),    32'd0);
    #2 Reset_n = 1'b1;
    cmp_en = 1;
    tick();

    // T1: bank0, 10 entries back to back
    ready_cnt = 0; done_cnt = 0;
    start_load(0, 10);
    for (int i = 0; i < 10; i++) feed(t1_data[i], 0);
    finish_load();
    check("t1_ready_cycles", 32'(ready_cnt), 32'd10);
    check("t1_done_pulses",  32'(done_cnt),  32'd1);
    BankSel = 2'd0; Addr = 5'd0; #1;
    check("t1_a0_tgt", 32'(Target), 32'h013);
    check("t1_a0_hit", 32'(Hit),    32'd1);
    Addr = 5'd10; #1;
    check("t1_a10_hit", 32'(Hit),    32'd0);
    check("t1_a10_tgt", 32'(Target), 32'd0);

    // T2: bank1, 4 entries with LoadValid toggling
    done_cnt = 0;
    start_load(1, 4);
    for (int i = 0; i < 4; i++) feed(TARGET_W'(10'h200 + i), 1);
    finish_load();
    check("t2_done_pulses", 32'(done_cnt), 32'd1);
    BankSel = 2'd1; Addr = 5'd3; #1;
    check("t2_a3_tgt", 32'(Target), 32'h203);
    Addr = 5'd4; #1;
    check("t2_a4_hit", 32'(Hit), 32'd0);
    BankSel = 2'd0; Addr = 5'd9; #1;
    check("t2_bank0_kept", 32'(Target), 32'h0c9);

    // T3: full-depth load, data = index
    ready_cnt = 0;
    start_load(2, 0);
    for (int i = 0; i < DEPTH; i++) feed(TARGET_W'(i), $urandom_range(0, 1));
    finish_load();
    BankSel = 2'd2; Addr = 5'd31; #1;
    check("t3_a31_tgt", 32'(Target), 32'd31);
    check("t3_a31_hit", 32'(Hit),    32'd1);
    Addr = 5'd0; #1;
    check("t3_a0_no_wrap_write", 32'(Target), 32'd0);

    // T4: abort after 3 accepts, with LoadValid high on the abort cycle
    done_before = done_cnt;
    start_load(2, 8);
    for (int i = 0; i < 3; i++) feed(TARGET_W'(10'h100 + i), 0);
    abort_now();
    check("t4_busy_after_abort", 32'(Busy), 32'd0);
    BankSel = 2'd2; Addr = 5'd2; #1;
    check("t4_a2_hit", 32'(Hit), 32'd1);
    Addr = 5'd3; #1;
    check("t4_a3_hit", 32'(Hit), 32'd0);
    tick();
    check("t4_no_done", 32'(done_cnt), 32'(done_before));

    // T5a: invalid bank
    start_load(3, 5);
    check("t5_err_pulse", 32'(LoadErr), 32'd1);
    check("t5_err_busy",  32'(Busy),    32'd0);
    tick();
    check("t5_err_single", 32'(LoadErr), 32'd0);

    // Randomized loads: any bank (including invalid), any length, stalls, aborts
    for (int r = 0; r < 12; r++) begin
      bank = $urandom_range(0, 3);
      len  = $urandom_range(0, DEPTH - 1);
      n    = (len == 0) ? DEPTH : len;
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      start_load(bank, len);
      if (bank < NUM_BANKS) begin
        for (int i = 0; i < n; i++) begin
          if (i == abort_at) begin
            abort_now();
            break;
          end
          feed(TARGET_W'($urandom), $urandom_range(0, 2));
        end
        if (abort_at < 0) finish_load();
      end
      repeat ($urandom_range(1, 3)) tick();
    end

    // T5b: reset in the middle of a load invalidates every bank at once
    start_load(1, 8);
    feed(10'h055, 0);
    feed(10'h0aa, 0);
    #1 Reset_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(LoadReady), 32'd0);
    check("t5_rst_busy",  32'(Busy),      32'd0);
    for (int b = 0; b < NUM_BANKS; b++) begin
      BankSel = BANK_W'(b);
      Addr = ADDR_W'($urandom_range(0, 9));
      #1;
      check("t5_rst_hit", 32'(Hit),    32'd0);
      check("t5_rst_tgt", 32'(Target), 32'd0);
    end
    @(negedge Clk);
    #1 Reset_n = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
